// File: rtl/mvm_pkg.sv
// Shared types and constants for the MVM result path.
package mvm_pkg;

    localparam int OWIDTH             = 32;
    localparam int NUM_OLANES         = 8;
    localparam int DEFAULT_FIFO_DEPTH = 16;
    localparam int LANEW              = $clog2(NUM_OLANES);

    typedef logic signed [OWIDTH-1:0] lane_word_t;
    typedef lane_word_t [NUM_OLANES-1:0] group_t;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        STREAM
    } out_state_t;

endpackage

// File: rtl/mvm_result_serializer_if.sv
// Group capture and lane stream signals between MVM engine, serializer and writeback consumer.
interface mvm_result_serializer_if #(
    parameter int FIFO_DEPTH = mvm_pkg::DEFAULT_FIFO_DEPTH
) ();

    localparam int CNTW = $clog2(FIFO_DEPTH + 1);

    mvm_pkg::lane_word_t          i_result [0:mvm_pkg::NUM_OLANES-1];
    logic                         i_valid;
    mvm_pkg::lane_word_t          o_data;
    logic [mvm_pkg::LANEW-1:0]    o_lane;
    logic                         o_last;
    logic                         o_valid;
    logic                         i_ready;
    logic [CNTW-1:0]              o_free;
    logic                         o_empty;
    logic                         o_overflow;
    logic                         i_clr_ovf;

    modport slave (
        input  i_result, i_valid, i_ready, i_clr_ovf,
        output o_data, o_lane, o_last, o_valid, o_free, o_empty, o_overflow
    );

    modport master (
        output i_result, i_valid, i_ready, i_clr_ovf,
        input  o_data, o_lane, o_last, o_valid, o_free, o_empty, o_overflow
    );

endinterface

// File: rtl/mvm_result_serializer_group_fifo.sv
// Synchronous FIFO of whole lane groups with a registered read port.
// The read address looks one entry past the head when the head is popped in the same cycle.
module group_fifo
    import mvm_pkg::*;
#(
    parameter int DEPTH = DEFAULT_FIFO_DEPTH,
    parameter int CNTW  = $clog2(DEPTH + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_wr_en,
    input  group_t          i_wr_data,
    input  logic            i_pop,
    input  logic            i_rd_en,
    output group_t          o_rd_data,
    output logic            o_full,
    output logic            o_empty,
    output logic [CNTW-1:0] o_count
);

    localparam int AW = $clog2(DEPTH);

    group_t          r_mem [0:DEPTH-1];
    group_t          r_rd_data;
    logic [AW:0]     r_wr_ptr;
    logic [AW:0]     r_rd_ptr;
    logic [AW:0]     w_diff;
    logic [AW-1:0]   w_wr_addr;
    logic [AW-1:0]   w_rd_addr;

    assign w_diff    = r_wr_ptr - r_rd_ptr;
    assign w_wr_addr = r_wr_ptr[AW-1:0];
    assign w_rd_addr = i_pop ? (r_rd_ptr[AW-1:0] + AW'(1)) : r_rd_ptr[AW-1:0];

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[w_wr_addr] <= i_wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_rd_data <= '0;
        end else begin
            if (i_wr_en) begin
                r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
            end
            if (i_rd_en) begin
                r_rd_data <= r_mem[w_rd_addr];
            end
        end
    end

    assign o_rd_data = r_rd_data;
    assign o_full    = (w_diff == (AW+1)'(DEPTH));
    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_count   = CNTW'(w_diff);

endmodule

// File: rtl/mvm_result_serializer.sv
// Buffers MVM lane groups and streams them out lane by lane over valid/ready,
// exporting free-space and a sticky overflow flag since the engine cannot stall.
module mvm_result_serializer
    import mvm_pkg::*;
#(
    parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
    input  logic                    clk,
    input  logic                    rst,
    mvm_result_serializer_if.slave  bus
);

    localparam int CNTW = $clog2(FIFO_DEPTH + 1);
    localparam logic [LANEW-1:0] LAST_LANE = LANEW'(NUM_OLANES - 1);

    group_t             w_wr_group;
    group_t             w_rd_data;
    logic               w_full;
    logic               w_fifo_empty;
    logic [CNTW-1:0]    w_count;
    logic               w_xfer;
    logic               w_pop;
    logic               w_push;
    logic               w_drop;
    logic               w_more;
    logic               w_rd_en;

    out_state_t         r_state;
    logic [LANEW-1:0]   r_lane;
    logic               r_valid;
    logic               r_ovf;

    always_comb begin
        w_wr_group = '0;
        for (int l = 0; l < NUM_OLANES; l++) begin
            w_wr_group[l] = bus.i_result[l];
        end
    end

    // A full FIFO still accepts a group when the head leaves on the same edge.
    assign w_xfer  = r_valid && bus.i_ready;
    assign w_pop   = w_xfer && (r_lane == LAST_LANE);
    assign w_push  = bus.i_valid && (!w_full || w_pop);
    assign w_drop  = bus.i_valid && w_full && !w_pop;
    assign w_more  = (w_count > CNTW'(1));
    assign w_rd_en = (r_state == FETCH) || (w_pop && w_more);

    group_fifo #(
        .DEPTH (FIFO_DEPTH),
        .CNTW  (CNTW)
    ) u_group_fifo (
        .clk       (clk),
        .rst       (rst),
        .i_wr_en   (w_push),
        .i_wr_data (w_wr_group),
        .i_pop     (w_pop),
        .i_rd_en   (w_rd_en),
        .o_rd_data (w_rd_data),
        .o_full    (w_full),
        .o_empty   (w_fifo_empty),
        .o_count   (w_count)
    );

    // A group pushed on the same edge as the final pop was not readable yet, so it takes the IDLE/FETCH path.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_lane  <= '0;
            r_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (!w_fifo_empty || w_push) begin
                        r_state <= FETCH;
                    end
                end
                FETCH: begin
                    r_state <= STREAM;
                    r_valid <= 1'b1;
                    r_lane  <= '0;
                end
                STREAM: begin
                    if (w_xfer) begin
                        if (r_lane == LAST_LANE) begin
                            r_lane <= '0;
                            if (!w_more) begin
                                r_state <= IDLE;
                                r_valid <= 1'b0;
                            end
                        end else begin
                            r_lane <= r_lane + LANEW'(1);
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_valid <= 1'b0;
                    r_lane  <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (w_drop) begin
            r_ovf <= 1'b1;
        end else if (bus.i_clr_ovf) begin
            r_ovf <= 1'b0;
        end
    end

    assign bus.o_data     = w_rd_data[r_lane];
    assign bus.o_lane     = r_lane;
    assign bus.o_last     = r_valid && (r_lane == LAST_LANE);
    assign bus.o_valid    = r_valid;
    assign bus.o_free     = CNTW'(FIFO_DEPTH) - w_count;
    assign bus.o_empty    = w_fifo_empty && !r_valid;
    assign bus.o_overflow = r_ovf;

endmodule
